ringosc_entropy_sampler: RTL and testbench

//  Consumer end of the ring-oscillator chain: samples one asynchronous ringoscillator output in the clk domain.

---
 rtl/entropy_pkg.sv | 13 +
 rtl/bit_synchronizer.sv | 20 ++
 rtl/ringosc_entropy_sampler.sv | 136 +++++++++++++
 tb/tb_ringosc_entropy_sampler.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/entropy_pkg.sv
// rtl/entropy_pkg.sv - FSM encodings and counter-width helper for the entropy sampler
package entropy_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FIRST  = 2'd1;
  localparam logic [1:0] ST_SECOND = 2'd2;

  // Counters hold 0..n-1; a one-value range still needs a single bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// rtl/bit_synchronizer.sv - multi-flop synchronizer bringing an async bit into the clk domain
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ringosc_entropy_sampler.sv
// rtl/ringosc_entropy_sampler.sv - ring-oscillator sampler, optional debias, word packer
// Von Neumann debiasing is built in when RINGOSC_VON_NEUMANN_EN is defined.
module ringosc_entropy_sampler
  import entropy_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SAMPLE_DIV  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_in,
  input  logic             enable,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overrun,
  input  logic             overrun_clr
);

  localparam int DIV_W = cnt_w(SAMPLE_DIV);
  localparam int BIT_W = cnt_w(WIDTH);

  logic             osc_s, tick, sample, bit_valid, bit_val, word_done, slot_free;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, shreg_shift, word_q, word_d;
  logic             valid_q, valid_d, ovr_q, ovr_d;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (osc_in),
    .q_o   (osc_s)
  );

  assign tick   = enable && (div_q == DIV_W'(SAMPLE_DIV - 1));
  // Ticks only count once the FSM has left IDLE.
  assign sample = tick && (state_q != ST_IDLE);

  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (!enable || tick) div_d = '0;
  end

`ifdef RINGOSC_VON_NEUMANN_EN
  logic first_q, first_d;

  always_comb begin
    first_d = first_q;
    if (sample && state_q == ST_FIRST) first_d = osc_s;
  end

  assign bit_valid = sample && (state_q == ST_SECOND) && (first_q != osc_s);
  assign bit_val   = first_q;

  always_ff @(posedge clk) begin
    if (rst) first_q <= 1'b0;
    else     first_q <= first_d;
  end
`else
  assign bit_valid = sample;
  assign bit_val   = osc_s;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_FIRST;
      default: begin
        if (!enable) state_d = ST_IDLE;
`ifdef RINGOSC_VON_NEUMANN_EN
        else if (sample) state_d = (state_q == ST_FIRST) ? ST_SECOND : ST_FIRST;
`endif
      end
    endcase
  end

  assign shreg_shift = {shreg_q[WIDTH-2:0], bit_val};
  assign word_done   = bit_valid && (bit_cnt_q == BIT_W'(WIDTH - 1));

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (!enable) begin
      shreg_d   = '0;
      bit_cnt_d = '0;
    end else if (bit_valid) begin
      shreg_d   = shreg_shift;
      bit_cnt_d = word_done ? '0 : bit_cnt_q + BIT_W'(1);
    end
  end

  // A finished word takes the output slot only if it is empty or draining this cycle.
  assign slot_free = !valid_q || word_ready;

  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (word_done && slot_free) begin
      word_d  = shreg_shift;
      valid_d = 1'b1;
    end else if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end
    if (overrun_clr) ovr_d = 1'b0;
    if (word_done && !slot_free) ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_ringosc_entropy_sampler.sv
// tb/tb_ringosc_entropy_sampler.sv - randomized self-checking bench against a bit-list reference model
module tb_ringosc_entropy_sampler;

  localparam int WA = 8;
  localparam int DA = 1;
  localparam int WB = 4;
  localparam int DB = 3;

  logic clk = 1'b0;
  logic rst, osc_in, enable, word_ready, overrun_clr;
  logic [WA-1:0] word_a;
  logic [WB-1:0] word_b;
  logic valid_a, ovr_a, valid_b, ovr_b;

  int total = 0;
  int bad   = 0;

  int W[2] = '{WA, WB};
  int D[2] = '{DA, DB};

  // Model: run length of enabled edges, bits collected as an integer, pending pair sample.
  int m_run[2], m_acc[2], m_n[2], m_have[2], m_a[2], m_word[2], m_valid[2], m_ovr[2];
  int n_run[2], n_acc[2], n_n[2], n_have[2], n_a[2], n_word[2], n_valid[2], n_ovr[2];
  int comp[2];
  int hist[2], n_hist[2];

  always #5 clk = ~clk;

  ringosc_entropy_sampler #(.WIDTH(WA), .SAMPLE_DIV(DA), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .osc_in(osc_in), .enable(enable),
    .word_out(word_a), .word_valid(valid_a), .word_ready(word_ready),
    .overrun(ovr_a), .overrun_clr(overrun_clr)
  );

  ringosc_entropy_sampler #(.WIDTH(WB), .SAMPLE_DIV(DB), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .osc_in(osc_in), .enable(enable),
    .word_out(word_b), .word_valid(valid_b), .word_ready(word_ready),
    .overrun(ovr_b), .overrun_clr(overrun_clr)
  );

  task automatic model_eval();
    int bitv;
    int full;
    int free;
    for (int i = 0; i < 2; i++) begin
      n_run[i] = m_run[i]; n_acc[i] = m_acc[i]; n_n[i] = m_n[i]; n_have[i] = m_have[i];
      n_a[i] = m_a[i]; n_word[i] = m_word[i]; n_valid[i] = m_valid[i]; n_ovr[i] = m_ovr[i];
      comp[i] = 0; bitv = -1; full = 0;
      if (rst) begin
        n_run[i] = 0; n_acc[i] = 0; n_n[i] = 0; n_have[i] = 0;
        n_a[i] = 0; n_word[i] = 0; n_valid[i] = 0; n_ovr[i] = 0;
      end else begin
        if (!enable) begin
          n_run[i] = 0; n_acc[i] = 0; n_n[i] = 0; n_have[i] = 0;
        end else begin
          n_run[i] = m_run[i] + 1;
          if (n_run[i] >= 2 && (n_run[i] % D[i]) == 0) begin
`ifdef RINGOSC_VON_NEUMANN_EN
            if (m_have[i] == 0) begin
              n_have[i] = 1; n_a[i] = hist[0];
            end else begin
              n_have[i] = 0;
              if (m_a[i] != hist[0]) bitv = m_a[i];
            end
`else
            bitv = hist[0];
`endif
          end
          if (bitv >= 0) begin
            n_acc[i] = m_acc[i] * 2 + bitv;
            n_n[i]   = m_n[i] + 1;
            if (n_n[i] == W[i]) begin
              comp[i] = 1; full = n_acc[i]; n_acc[i] = 0; n_n[i] = 0;
            end
          end
        end
        free = (m_valid[i] == 0 || word_ready) ? 1 : 0;
        if (comp[i] == 1 && free == 1) begin
          n_word[i] = full; n_valid[i] = 1;
        end else if (m_valid[i] == 1 && word_ready) begin
          n_valid[i] = 0;
        end
        if (overrun_clr) n_ovr[i] = 0;
        if (comp[i] == 1 && free == 0) n_ovr[i] = 1;
      end
    end
    if (rst) begin
      n_hist[0] = 0; n_hist[1] = 0;
    end else begin
      n_hist[0] = hist[1]; n_hist[1] = osc_in ? 1 : 0;
    end
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    m_run = n_run; m_acc = n_acc; m_n = n_n; m_have = n_have; m_a = n_a;
    m_word = n_word; m_valid = n_valid; m_ovr = n_ovr; hist = n_hist;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; word_ready = 1'b0; overrun_clr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      osc_in = c[0];
      step();
      total++;
      if ({word_a, valid_a, ovr_a, word_b, valid_b, ovr_b} !== '0) begin
        bad++;
        $display("FAIL reset c=%0d got a=%h/%b/%b b=%h/%b/%b required all zero",
                 c, word_a, valid_a, ovr_a, word_b, valid_b, ovr_b);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_raw_pattern();
    logic [7:0] p;
    p = 8'b1011_0010;
    rst = 1'b1; step(); rst = 1'b0;
    word_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      osc_in = (c < 8) ? p[7-c] : 1'b0;
      enable = (c >= 1);
      step();
      if (c == 8) begin
        total++;
        if (valid_a !== 1'(m_valid[0])) begin
          bad++; $display("FAIL raw_pre_valid got %b required %0d", valid_a, m_valid[0]);
        end
      end
    end
    total++;
    if (word_a !== WA'(m_word[0]) || valid_a !== 1'(m_valid[0])) begin
      bad++; $display("FAIL raw_a got %h/%b required %h/%0d", word_a, valid_a, WA'(m_word[0]), m_valid[0]);
    end
`ifndef RINGOSC_VON_NEUMANN_EN
    total++;
    if (word_a !== 8'hB2 || valid_a !== 1'b1) begin
      bad++; $display("FAIL raw_b2 got %h/%b required b2/1", word_a, valid_a);
    end
`endif
    total++;
    if (word_b !== WB'(m_word[1]) || valid_b !== 1'(m_valid[1]) || ovr_b !== 1'(m_ovr[1])) begin
      bad++; $display("FAIL raw_b got %h/%b/%b required %h/%0d/%0d",
                      word_b, valid_b, ovr_b, WB'(m_word[1]), m_valid[1], m_ovr[1]);
    end
  endtask

  task automatic test_debias();
    logic [11:0] s;
    int idx;
    s = 12'b10_01_11_00_10_10;
    rst = 1'b1; step(); rst = 1'b0;
    word_ready = 1'b0;
    for (int c = 0; c < 38; c++) begin
      idx = (c - 1) / 3;
      osc_in = (c >= 1 && idx < 12) ? s[11-idx] : 1'b0;
      enable = (c >= 1);
      step();
    end
    total++;
    if (word_b !== WB'(m_word[1]) || valid_b !== 1'(m_valid[1]) || ovr_b !== 1'(m_ovr[1])) begin
      bad++; $display("FAIL debias_b got %h/%b/%b required %h/%0d/%0d",
                      word_b, valid_b, ovr_b, WB'(m_word[1]), m_valid[1], m_ovr[1]);
    end
`ifdef RINGOSC_VON_NEUMANN_EN
    total++;
    if (word_b !== 4'b1011 || valid_b !== 1'b1 || ovr_b !== 1'b0) begin
      bad++; $display("FAIL debias_1011 got %b/%b/%b required 1011/1/0", word_b, valid_b, ovr_b);
    end
`endif
    total++;
    if (word_a !== WA'(m_word[0]) || valid_a !== 1'(m_valid[0]) || ovr_a !== 1'(m_ovr[0])) begin
      bad++; $display("FAIL debias_a got %h/%b/%b required %h/%0d/%0d",
                      word_a, valid_a, ovr_a, WA'(m_word[0]), m_valid[0], m_ovr[0]);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    enable = 1'b0; word_ready = 1'b1; step();
    word_ready = 1'b0; overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
    enable = 1'b1;
    cyc = 0;
    while (!(m_ovr[0] == 1 && m_ovr[1] == 1) && cyc < 2000) begin
      osc_in = 1'($urandom);
      step();
      cyc++;
      total++;
      if (word_a !== WA'(m_word[0]) || valid_a !== 1'(m_valid[0]) || ovr_a !== 1'(m_ovr[0]) ||
          word_b !== WB'(m_word[1]) || valid_b !== 1'(m_valid[1]) || ovr_b !== 1'(m_ovr[1])) begin
        bad++; $display("FAIL bp_hold cyc=%0d got a=%h/%b/%b b=%h/%b/%b", cyc,
                        word_a, valid_a, ovr_a, word_b, valid_b, ovr_b);
      end
    end
    total++;
    if (ovr_a !== 1'b1 || ovr_b !== 1'b1 || valid_a !== 1'b1 || valid_b !== 1'b1) begin
      bad++; $display("FAIL bp_overrun got ovr=%b/%b valid=%b/%b required 1/1 1/1 (cyc=%0d)",
                      ovr_a, ovr_b, valid_a, valid_b, cyc);
    end
    enable = 1'b0; overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
    total++;
    if (ovr_a !== 1'b0 || ovr_b !== 1'b0 || valid_a !== 1'b1 || word_a !== WA'(m_word[0])) begin
      bad++; $display("FAIL bp_clear got ovr=%b/%b valid_a=%b w=%h required 0/0 1 %h",
                      ovr_a, ovr_b, valid_a, word_a, WA'(m_word[0]));
    end
  endtask

  task automatic test_simultaneous();
    int cyc;
    bit hit;
    enable = 1'b1; word_ready = 1'b0;
    hit = 0; cyc = 0;
    while (!hit && cyc < 400) begin
      osc_in = 1'($urandom);
      word_ready = 1'b0;
      model_eval();
      if (comp[0] == 1) begin
        word_ready = 1'b1;
        hit = 1;
      end
      step();
      cyc++;
    end
    total++;
    if (!hit) begin
      bad++; $display("FAIL simul_timeout no completion within %0d cycles", cyc);
    end else if (valid_a !== 1'b1 || ovr_a !== 1'b0 || word_a !== WA'(m_word[0])) begin
      bad++; $display("FAIL simul got %b/%b/%h required 1/0/%h", valid_a, ovr_a, word_a, WA'(m_word[0]));
    end
    total++;
    if (word_b !== WB'(m_word[1]) || valid_b !== 1'(m_valid[1]) || ovr_b !== 1'(m_ovr[1])) begin
      bad++; $display("FAIL simul_b got %h/%b/%b required %h/%0d/%0d",
                      word_b, valid_b, ovr_b, WB'(m_word[1]), m_valid[1], m_ovr[1]);
    end
    word_ready = 1'b0;
  endtask

  task automatic test_enable_drop();
    int cyc;
    int pend;
    enable = 1'b1; word_ready = 1'b0; cyc = 0;
    while (!(m_valid[0] == 1 && m_n[0] == 5) && cyc < 400) begin
      osc_in = 1'($urandom);
      step();
      cyc++;
    end
    total++;
    if (cyc >= 400) begin
      bad++; $display("FAIL drop_timeout partial word of 5 bits not reached");
    end
    pend = m_word[0];
    enable = 1'b0;
    step(); step();
    total++;
    if (valid_a !== 1'b1 || word_a !== WA'(pend)) begin
      bad++; $display("FAIL drop_pending got %b/%h required 1/%h", valid_a, word_a, WA'(pend));
    end
    word_ready = 1'b1; step(); word_ready = 1'b0;
    total++;
    if (valid_a !== 1'b0) begin
      bad++; $display("FAIL drop_deliver got valid=%b required 0", valid_a);
    end
    enable = 1'b1; cyc = 0;
    while (m_valid[0] == 0 && cyc < 400) begin
      osc_in = 1'($urandom);
      step();
      cyc++;
    end
    total++;
    if (valid_a !== 1'(m_valid[0]) || word_a !== WA'(m_word[0]) || ovr_a !== 1'(m_ovr[0])) begin
      bad++; $display("FAIL drop_fresh got %b/%h/%b required %0d/%h/%0d",
                      valid_a, word_a, ovr_a, m_valid[0], WA'(m_word[0]), m_ovr[0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 199) == 0);
      enable      = ($urandom_range(0, 15) != 0);
      word_ready  = 1'($urandom);
      overrun_clr = ($urandom_range(0, 19) == 0);
      osc_in      = 1'($urandom);
      step();
      total++;
      if (word_a !== WA'(m_word[0]) || valid_a !== 1'(m_valid[0]) || ovr_a !== 1'(m_ovr[0]) ||
          word_b !== WB'(m_word[1]) || valid_b !== 1'(m_valid[1]) || ovr_b !== 1'(m_ovr[1])) begin
        bad++;
        $display("FAIL random c=%0d got a=%h/%b/%b b=%h/%b/%b required a=%h/%0d/%0d b=%h/%0d/%0d",
                 c, word_a, valid_a, ovr_a, word_b, valid_b, ovr_b,
                 WA'(m_word[0]), m_valid[0], m_ovr[0], WB'(m_word[1]), m_valid[1], m_ovr[1]);
      end
    end
    rst = 1'b0; overrun_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; osc_in = 1'b0; enable = 1'b0; word_ready = 1'b0; overrun_clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_acc[i] = 0; m_n[i] = 0; m_have[i] = 0;
      m_a[i] = 0; m_word[i] = 0; m_valid[i] = 0; m_ovr[i] = 0; hist[i] = 0;
    end
    @(negedge clk);
    test_reset();
    test_raw_pattern();
    test_debias();
    test_backpressure();
    test_simultaneous();
    test_enable_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
